// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_pkg
//  Description : Shared types and constants for the data-memory subsystem.
//  Revision    : 1.0  initial release
// ============================================================================
package soc_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CORE_RD = 2'd1,
      SCAN_RD = 2'd2
   } arb_state_t;

   // Word-address width of the data RAM
   localparam int DMEM_ADDR_W = 6;

   // First RAM word holding the seven-segment digits
   localparam int SEG_MEM_MAP = 0;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : refresh_timer
//  Description : Free-running 0..CYCLES-1 counter; tick is high during the
//                wrap cycle (count == CYCLES-1).
//  Revision    : 1.0  initial release
// ============================================================================
module refresh_timer #(
   parameter int CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int c_CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CYCLES - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Wrap counter: restarts at zero after the last count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Single-port data-RAM arbiter. The core load/store port has
//                priority; a background engine periodically reads the display
//                words into a nibble shadow register. A starvation guard
//                forces one scan slot after MAX_WAIT blocked cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
   import soc_pkg::*;
#(
   parameter int ADDR_W         = DMEM_ADDR_W,
   parameter int DISP_BASE      = SEG_MEM_MAP,
   parameter int DISP_WORDS     = 4,
   parameter int REFRESH_CYCLES = 1024,
   parameter int MAX_WAIT       = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    core_req,
   input  logic                    core_we,
   input  logic [31:0]             core_addr,
   input  logic [31:0]             core_wdata,
   output logic [31:0]             core_rdata,
   output logic                    core_ready,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata,
   output logic [4*DISP_WORDS-1:0] disp_nibbles,
   output logic                    disp_valid
);

   localparam int c_IDX_W  = (DISP_WORDS > 1) ? $clog2(DISP_WORDS) : 1;
   localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(DISP_WORDS - 1);
   localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

   arb_state_t               r_state, w_next;
   logic [c_IDX_W-1:0]       r_scan_idx;
   logic                     r_scan_pending;
   logic [c_WAIT_W-1:0]      r_wait;
   logic                     r_oor_rd;
   logic [31:0]              r_rdata;
   logic [4*DISP_WORDS-1:0]  r_nibbles;
   logic                     r_valid;

   logic                     w_tick;
   logic                     w_force;
   logic                     w_oor;
   logic [ADDR_W-1:0]        w_word;
   logic [ADDR_W-1:0]        w_scan_addr;
   logic                     w_scan_grant;
   logic                     w_core_rd_grant;
   logic                     w_scan_done;
   logic [31:0]              w_rd_data;
   logic                     w_unused_addr_bits;

   refresh_timer #(
      .CYCLES (REFRESH_CYCLES)
   ) u_refresh (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   assign w_word             = core_addr[ADDR_W+1:2];
   assign w_oor              = |core_addr[31:ADDR_W+2];
   assign w_scan_addr        = ADDR_W'(DISP_BASE) + ADDR_W'(r_scan_idx);
   assign w_force            = r_scan_pending && (r_wait == c_MAX_WAIT);
   assign w_scan_done        = (r_state == SCAN_RD) && (r_scan_idx == c_LAST_IDX);
   assign w_unused_addr_bits = ^core_addr[1:0];

   // Read data is live from the RAM while core_ready is up, then held
   assign w_rd_data  = r_oor_rd ? 32'd0 : mem_rdata;
   assign core_rdata = (r_state == CORE_RD) ? w_rd_data : r_rdata;

   assign disp_nibbles = r_nibbles;
   assign disp_valid   = r_valid;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Grant decision, next state and RAM/core strobes
   always_comb begin
      w_next          = r_state;
      mem_en          = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = w_word;
      mem_wdata       = core_wdata;
      core_ready      = 1'b0;
      w_scan_grant    = 1'b0;
      w_core_rd_grant = 1'b0;
      case (r_state)
         IDLE: begin
            if (core_req && !w_force) begin
               if (core_we) begin
                  mem_en     = !w_oor;
                  mem_we     = !w_oor;
                  core_ready = 1'b1;
               end else begin
                  mem_en          = !w_oor;
                  w_core_rd_grant = 1'b1;
                  w_next          = CORE_RD;
               end
            end else if (r_scan_pending) begin
               mem_en       = 1'b1;
               mem_addr     = w_scan_addr;
               w_scan_grant = 1'b1;
               w_next       = SCAN_RD;
            end
         end
         CORE_RD: begin
            core_ready = 1'b1;
            w_next     = IDLE;
         end
         SCAN_RD: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Core read bookkeeping: range flag and held read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_oor_rd <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_core_rd_grant) begin
            r_oor_rd <= w_oor;
         end
         if (r_state == CORE_RD) begin
            r_rdata <= w_rd_data;
         end
      end
   end

   // Scan engine: pending flag, word index, shadow nibbles and valid flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_pending <= 1'b0;
         r_scan_idx     <= '0;
         r_nibbles      <= '0;
         r_valid        <= 1'b0;
      end else begin
         if (r_state == SCAN_RD) begin
            r_nibbles[4*r_scan_idx +: 4] <= mem_rdata[3:0];
            if (w_scan_done) begin
               r_scan_idx <= '0;
               r_valid    <= 1'b1;
            end else begin
               r_scan_idx <= r_scan_idx + 1'b1;
            end
         end
         // A wrap in the completion cycle re-arms the scan; a wrap while
         // already pending is simply absorbed.
         if (w_scan_done) begin
            r_scan_pending <= 1'b0;
         end
         if (w_tick) begin
            r_scan_pending <= 1'b1;
         end
      end
   end

   // Starvation counter: counts cycles a pending scan is held off by the
   // core (not the scan's own read cycle), saturating at MAX_WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait <= '0;
      end else if (w_scan_grant) begin
         r_wait <= '0;
      end else if (r_scan_pending && (r_state != SCAN_RD) && (r_wait != c_MAX_WAIT)) begin
         r_wait <= r_wait + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                synchronous-read RAM model (REFRESH_CYCLES=16, MAX_WAIT=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int ADDR_W = 6;
   localparam int DISP_WORDS = 4;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    core_req;
   logic                    core_we;
   logic [31:0]             core_addr;
   logic [31:0]             core_wdata;
   logic [31:0]             core_rdata;
   logic                    core_ready;
   logic                    mem_en;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [31:0]             mem_wdata;
   logic [31:0]             mem_rdata = 32'd0;
   logic [4*DISP_WORDS-1:0] disp_nibbles;
   logic                    disp_valid;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] ram [64] = '{0: 32'h1, 1: 32'h2, 2: 32'h2, 3: 32'h2, default: 32'h0};

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W         (ADDR_W),
      .DISP_BASE      (0),
      .DISP_WORDS     (DISP_WORDS),
      .REFRESH_CYCLES (16),
      .MAX_WAIT       (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .core_req     (core_req),
      .core_we      (core_we),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .core_rdata   (core_rdata),
      .core_ready   (core_ready),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .disp_nibbles (disp_nibbles),
      .disp_valid   (disp_valid)
   );

   // Synchronous-read single-port RAM
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to n negedges later, then a little past it
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; core_req = 1'b0; core_we = 1'b0;
      core_addr = 32'd0; core_wdata = 32'd0;

      // Reset state
      cyc(2);
      chk("rst_nibbles", 32'(disp_nibbles), 32'h0);
      chk("rst_valid",   32'(disp_valid),   32'h0);
      chk("rst_ready",   32'(core_ready),   32'h0);
      chk("rst_mem_en",  32'(mem_en),       32'h0);
      chk("rst_mem_we",  32'(mem_we),       32'h0);
      chk("rst_rdata",   core_rdata,        32'h0);
      reset = 1'b0;                                      // N0

      // First scan at cycle 16, valid after 8 more cycles
      cyc(15);                                           // N15
      chk("scan_not_yet", 32'(mem_en), 32'h0);
      cyc(1);                                            // N16
      chk("scan0_en",   32'(mem_en),   32'h1);
      chk("scan0_addr", 32'(mem_addr), 32'h0);
      cyc(7);                                            // N23
      chk("valid_early", 32'(disp_valid), 32'h0);
      cyc(1);                                            // N24
      chk("valid_set",    32'(disp_valid),   32'h1);
      chk("nibbles_2221", 32'(disp_nibbles), 32'h2221);

      // Core write then read of word 1
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h4; core_wdata = 32'hA;
      #1;
      chk("wr_ready", 32'(core_ready), 32'h1);
      chk("wr_en",    32'(mem_en),     32'h1);
      chk("wr_we",    32'(mem_we),     32'h1);
      chk("wr_addr",  32'(mem_addr),   32'h1);
      cyc(1);                                            // N25
      core_we = 1'b0;
      #1;
      chk("rd_ready0", 32'(core_ready), 32'h0);
      chk("rd_en",     32'(mem_en),     32'h1);
      chk("rd_we",     32'(mem_we),     32'h0);
      cyc(1);                                            // N26
      chk("rd_ready1", 32'(core_ready), 32'h1);
      chk("rd_data",   core_rdata,      32'hA);
      core_req = 1'b0;
      cyc(1);                                            // N27
      chk("rd_ready_drop", 32'(core_ready), 32'h0);
      chk("rd_data_held",  core_rdata,      32'hA);
      cyc(13);                                           // N40
      chk("nibbles_22A1", 32'(disp_nibbles), 32'h22A1);

      // Starvation: back-to-back writes, scan pending from N48
      cyc(6);                                            // N46
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h5;
      cyc(9);                                            // N55
      chk("starve_ready_n55", 32'(core_ready), 32'h1);
      cyc(1);                                            // N56
      chk("force_ready", 32'(core_ready), 32'h0);
      chk("force_en",    32'(mem_en),     32'h1);
      chk("force_we",    32'(mem_we),     32'h0);
      chk("force_addr",  32'(mem_addr),   32'h0);
      cyc(1);                                            // N57
      chk("force_scanrd_ready", 32'(core_ready), 32'h0);
      cyc(1);                                            // N58
      chk("after_force_ready", 32'(core_ready), 32'h1);
      cyc(7);                                            // N65
      chk("wait_restart_ready", 32'(core_ready), 32'h1);
      cyc(1);                                            // N66
      chk("force2_ready", 32'(core_ready), 32'h0);
      chk("force2_addr",  32'(mem_addr),   32'h1);
      cyc(1);                                            // N67
      core_req = 1'b0;

      // Out-of-range accesses
      cyc(5);                                            // N72
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'h7;
      #1;
      chk("oor_wr_ready", 32'(core_ready), 32'h1);
      chk("oor_wr_en",    32'(mem_en),     32'h0);
      cyc(1);                                            // N73
      core_we = 1'b0;
      #1;
      chk("oor_rd_en",     32'(mem_en),     32'h0);
      chk("oor_rd_ready0", 32'(core_ready), 32'h0);
      cyc(1);                                            // N74
      chk("oor_rd_ready1", 32'(core_ready), 32'h1);
      chk("oor_rd_data",   core_rdata,      32'h0);
      core_req = 1'b0;
      cyc(1);                                            // N75
      chk("oor_rd_held", core_rdata, 32'h0);

      // Reset while the scan reads word 2 (scan granted from N80)
      cyc(10);                                           // N85
      reset = 1'b1;
      #1;
      chk("midrst_nibbles", 32'(disp_nibbles), 32'h0);
      chk("midrst_valid",   32'(disp_valid),   32'h0);
      chk("midrst_en",      32'(mem_en),       32'h0);
      chk("midrst_ready",   32'(core_ready),   32'h0);
      cyc(2);                                            // N87
      reset = 1'b0;
      cyc(15);                                           // N102
      chk("post_rst_no_scan", 32'(mem_en), 32'h0);

      // Delay the scan with writes so its last word lands on the next wrap
      cyc(1);                                            // N103
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h24; core_wdata = 32'hF;
      #1;
      chk("delay_wr_ready", 32'(core_ready), 32'h1);
      cyc(8);                                            // N111
      chk("post_rst_force_ready", 32'(core_ready), 32'h0);
      chk("post_rst_force_en",    32'(mem_en),     32'h1);
      chk("post_rst_idx0",        32'(mem_addr),   32'h0);
      core_req = 1'b0;
      cyc(7);                                            // N118
      chk("coinc_valid_before", 32'(disp_valid), 32'h0);
      chk("coinc_last_rd_en",   32'(mem_en),     32'h0);
      cyc(1);                                            // N119
      chk("coinc_rescan_en",   32'(mem_en),       32'h1);
      chk("coinc_rescan_addr", 32'(mem_addr),     32'h0);
      chk("coinc_valid",       32'(disp_valid),   32'h1);
      chk("coinc_nibbles",     32'(disp_nibbles), 32'h22A1);
      cyc(1);                                            // N120
      chk("coinc_scanrd_en", 32'(mem_en), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
